// File: rtl/full_handshake_rx.sv
// full_handshake_rx: receive end of a four-phase req/ack clock-domain-crossing
// handshake. The request is synchronized into the RX clock, the TX data word
// is captured once the synchronized request is seen, the transfer is
// acknowledged, and the word is handed to a local consumer through a
// one-entry valid/ready buffer.
// Build option: define FULL_HANDSHAKE_RX_SYNC3_EN for a 3-flop request
// synchronizer (default 2 flops).
`timescale 1ns/1ps

module full_handshake_rx #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic [DW-1:0] req_data_i,
    output logic          ack_o,
    output logic          recv_vld_o,
    output logic [DW-1:0] recv_data_o,
    input  logic          recv_rdy_i,
    output logic          idle_o
);

`ifdef FULL_HANDSHAKE_RX_SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        ACK  = 2'b10
    } state_t;

    state_t                state;
    logic [SYNC_DEPTH-1:0] req_sync_p0;
    logic                  req_s;
    logic                  buf_free;
    logic                  capture;
    logic                  vld_nxt;

    // Request synchronizer; the data bus is not synchronized because it is
    // only sampled once req_s proves it has been stable for the sync depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_p0 <= '0;
        end else begin
            req_sync_p0 <= {req_sync_p0[SYNC_DEPTH-2:0], req_i};
        end
    end

    assign req_s    = req_sync_p0[SYNC_DEPTH-1];
    assign buf_free = !recv_vld_o || recv_rdy_i;
    // Only a legal IDLE state may capture; an illegal encoding never does.
    assign capture  = (state == IDLE) && req_s && buf_free;
    // A capture in the same cycle as an accept keeps the buffer full.
    assign vld_nxt  = capture || (recv_vld_o && !recv_rdy_i);

    // One-entry output buffer: load on capture, drain on consumer accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recv_vld_o  <= 1'b0;
            recv_data_o <= '0;
        end else begin
            recv_vld_o <= vld_nxt;
            if (capture) begin
                recv_data_o <= req_data_i;
            end
        end
    end

    // Handshake FSM with registered ack and idle outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ack_o  <= 1'b0;
            idle_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        state  <= ACK;
                        ack_o  <= 1'b1;
                        idle_o <= 1'b0;
                    end else begin
                        // Either no request or backpressure: TX stalls on ack=0.
                        state  <= IDLE;
                        ack_o  <= 1'b0;
                        idle_o <= !vld_nxt;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        state  <= IDLE;
                        ack_o  <= 1'b0;
                        idle_o <= !vld_nxt;
                    end else begin
                        state  <= ACK;
                        ack_o  <= 1'b1;
                        idle_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ack_o  <= 1'b0;
                    idle_o <= !vld_nxt;
                end
            endcase
        end
    end

endmodule

// File: doc/full_handshake_rx.md
# full_handshake_rx

Receive end of the four-phase clock-domain-crossing handshake: req high, ack high, req low, ack low. The block synchronizes the incoming request into the local clock domain and captures the request data. It acknowledges the transfer and presents the word to a local consumer through a one-entry valid/ready buffer. It sits in the RX clock domain opposite the full-handshake transmitter; `req_i`, `req_data_i` and `ack_o` are the only signals that cross domains.

## Interface
- `DW`, 32, data width in bits (≥1)
- `clk` input 1, RX domain clock
- `rst_n` input 1, asynchronous active-low reset
- `req_i` input 1, request from TX domain (asynchronous to `clk`)
- `req_data_i` input DW, data from TX domain; stable while `req_i` high
- `ack_o` output 1, acknowledge to TX domain; driven directly from a flop
- `recv_vld_o` output 1, buffered word valid to local consumer
- `recv_data_o` output DW, buffered word
- `recv_rdy_i` input 1, consumer accepts word when `recv_vld_o && recv_rdy_i` at a rising edge
- `idle_o` output 1, high in IDLE with empty buffer

## Operation
- Reset values: `ack_o`=0, `recv_vld_o`=0, `recv_data_o`=0, `idle_o`=1, state IDLE, synchronizer flops 0.
- `req_i` passes through a 2-flop synchronizer (3 flops with the macro) to form `req_s`. `req_data_i` is never synchronized. It is sampled only when `req_s`=1, which guarantees it has been stable for at least the synchronizer depth.
- `buf_free` = `!recv_vld_o || recv_rdy_i`.
- State IDLE (one-hot 2'b01):
  - When `req_s`=1 and `buf_free`=1, capture `req_data_i` into `recv_data_o`, set `recv_vld_o`=1 and `ack_o`=1, and go to ACK.
  - When `req_s`=1 and `buf_free`=0, stay in IDLE with `ack_o`=0. This is backpressure, and TX stalls.
- State ACK (2'b10):
  - Hold `ack_o`=1 while `req_s`=1.
  - When `req_s`=0, set `ack_o`=0 and go to IDLE.
  - A new request is not considered until the state is back in IDLE.
- Illegal state encoding: next state IDLE, `ack_o`=0. `recv_vld_o` and `recv_data_o` are unaffected.
- Consumer side is independent of the FSM. `recv_vld_o` clears on accept unless a capture happens in the same cycle.
- Simultaneous accept and capture: `recv_vld_o` stays 1 and `recv_data_o` takes the new word, so there is no bubble and no loss.
- `recv_data_o` holds its last value after accept; it is not cleared.
- `idle_o` = (state==IDLE) && !`recv_vld_o`, registered alongside the state.
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronous). A TX that is waiting sees `ack_o`=0; a pending word is lost.

## Timing
- Let `req_i` rise before edge E0. `req_s`=1 after E1 (after E2 with the macro). Capture happens at the following edge. `ack_o` and `recv_vld_o` go high after E2 (E3 with the macro), provided `buf_free`.
- Let `req_i` fall before edge F0. `ack_o` goes low after F2 (F3 with the macro).
- Minimum RX-side cycle per transfer with an always-ready consumer is 2×(sync depth + 1) RX clocks, plus TX-side synchronizer latency.
- `recv_vld_o` to accept: zero-cycle combinational dependency on `recv_rdy_i` only in the `buf_free` term. `recv_rdy_i` never reaches any output combinationally.
- Backpressure: `ack_o` rises at the edge after `buf_free` becomes 1 while `req_s`=1.

## Configuration
- `FULL_HANDSHAKE_RX_SYNC3_EN`:
  - Defined: the `req_i` synchronizer is 3 flops, and every request-related latency above grows by 1 cycle.
  - Undefined: the synchronizer is 2 flops.
  - Data capture and FSM behaviour are otherwise identical.

## Test plan
- Single transfer, `recv_rdy_i`=1, DW=32. Drive `req_i`=1 with data 0xDEADBEEF. Required response:
  - `ack_o`=1 and `recv_vld_o`=1 with `recv_data_o`=0xDEADBEEF, 2 edges after first sample (3 with the macro).
  - `recv_vld_o` drops 1 cycle later.
  - `ack_o`=0 2 edges after `req_i` falls.
- Backpressure. Hold `recv_rdy_i`=0 with the buffer holding 0x1, then raise `req_i` with 0x2. Required response:
  - `ack_o` stays 0 and `recv_data_o` stays 0x1 for 10 cycles.
  - Raise `recv_rdy_i`: at the next edge 0x1 is accepted, 0x2 is captured, `recv_vld_o` stays 1 and `ack_o` rises.
- Back-to-back. A TX model sends 0x10..0x1F with random `recv_rdy_i`. Required response: the consumer sees exactly 16 words in order, with no duplicates and no drops.
- Reset mid-ACK. Assert `rst_n`=0 while `ack_o`=1. Required response: `ack_o`=0, `recv_vld_o`=0, `recv_data_o`=0 and `idle_o`=1 without waiting for a clock edge. After release, a held `req_i` is captured again.
- Protocol check. `req_i` toggles only after `ack_o` changes. Required response: `ack_o` never falls while the synchronized `req` is high, and never rises twice per request.
- Asynchronous clocks. Run TX:RX clock ratios of 3:1 and 1:3 with 100 transfers each. Required response: data integrity holds, and `req_data_i` is never sampled while `req_s`=0.
